// File: rtl/softmax_pkg.sv
// Shared types and Q6.10 constants for the softmax RU sequencer.
//   ONE/LOG2E/SAT16 : Q6.10 constants (1.0, log2(e) as applied by the RU, max positive)
//   q610_t          : signed Q6.10 scalar
//   state_t         : sequencer phase
package softmax_pkg;

    localparam logic [15:0] ONE   = 16'h0400;
    localparam logic [15:0] LOG2E = 16'h05C4;
    localparam logic [15:0] SAT16 = 16'h7FFF;

    typedef logic signed [15:0] q610_t;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StExpIssue,
        StExpDrain,
        StNormIssue,
        StNormDrain
    } state_t;

endpackage

// File: rtl/sm_vec_buf.sv
// Vector buffer: DEPTH x Q6.10 simple dual-port RAM.
//   clk     : clock
//   i_we    : write strobe, i_waddr/i_wdata write address/data
//   i_re    : read strobe, i_raddr read address
//   o_rdata : registered read data, holds its value while i_re is low
module sm_vec_buf
    import softmax_pkg::*;
#(
    parameter int unsigned DEPTH = 64,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  q610_t         i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output q610_t         o_rdata
);

    q610_t r_mem [DEPTH];
    q610_t r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/softmax_ru_sequencer.sv
// Softmax sequencer driving the RU log2/pow2 reduction unit.
//   in_*     : logit stream (signed Q6.10), in_last marks the final beat
//   out_*    : softmax probability stream (Q6.10), out_last marks the final beat
//   busy     : high outside IDLE/LOAD; len_err pulses when a vector is cut at MAX_LEN
//   ru_*     : RU enable, operand selects, issue strobe/operands and result inputs
// Phases: LOAD buffers logits and tracks the max; EXP issues (max, x) and writes t back
// while summing e; NORM issues (sum, t) and streams y = 2^(t - log2 sum).
module softmax_ru_sequencer
    import softmax_pkg::*;
#(
    parameter int unsigned MAX_LEN = 64,
    parameter int unsigned ACC_W   = 24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic        out_last,
    output logic        busy,
    output logic        len_err,
    output logic        ru_en,
    output logic        ru_sel_mult,
    output logic        ru_sel_mux,
    output logic        ru_valid_in,
    output logic [15:0] ru_in_0,
    output logic [15:0] ru_in_1,
    input  logic        ru_valid_out,
    input  logic [15:0] ru_out_0,
    input  logic [15:0] ru_out_1
);

    localparam int unsigned AW = $clog2(MAX_LEN);
    localparam int unsigned CW = AW + 1;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    r_len;
    logic [CW-1:0]    r_rd;
    logic [CW-1:0]    r_wr;
    q610_t            r_max;
    logic [ACC_W-1:0] r_sum;
    logic             r_vin;
    logic             r_sel_mux;
    logic             r_sel_mult;
    logic             r_out_valid;
    logic [15:0]      r_out_data;
    logic             r_out_last;
    logic             r_len_err;

    logic             w_loading;
    logic             w_norm;
    logic             w_exp;
    logic             w_issuing;
    logic             w_in_fire;
    logic             w_ru_fire;
    logic             w_wb_exp;
    logic             w_wb_norm;
    logic             w_rd_en;
    logic             w_last_rd;
    logic             w_cut;
    logic [ACC_W:0]   w_sum_add;
    logic [ACC_W-1:0] w_sum_nxt;
    logic [15:0]      w_sum_clamp;
    q610_t            w_rdata;
    logic             w_we;
    logic [AW-1:0]    w_waddr;
    q610_t            w_wdata;

    assign w_loading = (r_state == StIdle) || (r_state == StLoad);
    assign w_exp     = (r_state == StExpIssue) || (r_state == StExpDrain);
    assign w_norm    = (r_state == StNormIssue) || (r_state == StNormDrain);
    assign w_issuing = (r_state == StExpIssue) || (r_state == StNormIssue);

    // RU pipeline freezes while a finished result waits downstream; idle RU is parked.
    assign ru_en     = !w_loading && !(r_out_valid && !out_ready);
    assign in_ready  = w_loading;
    assign busy      = !w_loading;

    assign w_in_fire = in_valid && in_ready;
    assign w_ru_fire = ru_valid_out && ru_en;
    assign w_wb_exp  = w_ru_fire && w_exp;
    assign w_wb_norm = w_ru_fire && w_norm;
    assign w_rd_en   = ru_en && w_issuing;
    assign w_last_rd = (r_rd == r_len - CW'(1));
    assign w_cut     = (r_cnt == CW'(MAX_LEN - 1));

    // Saturating accumulate of the zero-extended pow2 result.
    assign w_sum_add   = {1'b0, r_sum} + {{(ACC_W + 1 - 16){1'b0}}, ru_out_1};
    assign w_sum_nxt   = w_sum_add[ACC_W] ? '1 : w_sum_add[ACC_W-1:0];
    assign w_sum_clamp = (r_sum > ACC_W'(SAT16)) ? SAT16 : r_sum[15:0];

    // Load and EXP write-back never overlap, so one write port suffices.
    assign w_we    = w_in_fire || w_wb_exp;
    assign w_waddr = w_in_fire ? r_cnt[AW-1:0] : r_wr[AW-1:0];
    assign w_wdata = w_in_fire ? q610_t'(in_data) : q610_t'(ru_out_0);

    sm_vec_buf #(
        .DEPTH (MAX_LEN)
    ) u_buf (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_re    (w_rd_en),
        .i_raddr (r_rd[AW-1:0]),
        .o_rdata (w_rdata)
    );

    assign ru_valid_in = r_vin;
    assign ru_sel_mux  = r_sel_mux;
    assign ru_sel_mult = r_sel_mult;
    assign ru_in_0     = w_norm ? w_sum_clamp : r_max;
    assign ru_in_1     = w_rdata;
    assign out_valid   = r_out_valid;
    assign out_data    = r_out_data;
    assign out_last    = r_out_last;
    assign len_err     = r_len_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= StIdle;
            r_cnt       <= '0;
            r_len       <= '0;
            r_rd        <= '0;
            r_wr        <= '0;
            r_max       <= '0;
            r_sum       <= '0;
            r_vin       <= 1'b0;
            r_sel_mux   <= 1'b0;
            r_sel_mult  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_len_err   <= 1'b0;
        end else begin
            r_len_err <= 1'b0;

            // Issue stage: the read done this cycle is presented to the RU next cycle.
            if (ru_en) begin
                r_vin <= w_issuing;
            end
            if (w_rd_en) begin
                r_rd <= r_rd + CW'(1);
            end

            if (w_wb_exp) begin
                r_sum <= w_sum_nxt;
                r_wr  <= r_wr + CW'(1);
            end

            if (w_wb_norm) begin
                r_out_valid <= 1'b1;
                r_out_data  <= ru_out_1;
                r_out_last  <= (r_wr == r_len - CW'(1));
                r_wr        <= r_wr + CW'(1);
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end

            unique case (r_state)
                StIdle, StLoad: begin
                    if (w_in_fire) begin
                        if (r_state == StIdle || q610_t'(in_data) > r_max) begin
                            r_max <= q610_t'(in_data);
                        end
                        if (r_state == StIdle) begin
                            r_sum <= '0;
                        end
                        if (in_last || w_cut) begin
                            r_len      <= r_cnt + CW'(1);
                            r_cnt      <= '0;
                            r_rd       <= '0;
                            r_wr       <= '0;
                            r_sel_mux  <= 1'b1;
                            r_sel_mult <= 1'b1;
                            r_len_err  <= w_cut && !in_last;
                            r_state    <= StExpIssue;
                        end else begin
                            r_cnt   <= r_cnt + CW'(1);
                            r_state <= StLoad;
                        end
                    end
                end
                StExpIssue: begin
                    if (w_rd_en && w_last_rd) begin
                        r_state <= StExpDrain;
                    end
                end
                StExpDrain: begin
                    // RU is empty once the last t is back, so selects may switch here.
                    if (w_wb_exp && r_wr == r_len - CW'(1)) begin
                        r_rd       <= '0;
                        r_wr       <= '0;
                        r_sel_mux  <= 1'b0;
                        r_sel_mult <= 1'b0;
                        r_state    <= StNormIssue;
                    end
                end
                StNormIssue: begin
                    if (w_rd_en && w_last_rd) begin
                        r_state <= StNormDrain;
                    end
                end
                StNormDrain: begin
                    if (r_out_valid && out_ready && r_out_last) begin
                        r_state <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_softmax_ru_sequencer.sv
// Bench for softmax_ru_sequencer with a behavioural RU (fixed-depth pipeline, real math)
// and a softmax reference computed directly from the logits.
module tb_softmax_ru_sequencer;

    localparam int MAX_LEN  = 64;
    localparam int ACC_W    = 24;
    localparam int RU_DEPTH = 3;
    localparam int TOL      = 20;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_last;
    logic [15:0] in_data;
    logic        out_valid, out_ready, out_last;
    logic [15:0] out_data;
    logic        busy, len_err;
    logic        ru_en, ru_sel_mult, ru_sel_mux, ru_valid_in;
    logic [15:0] ru_in_0, ru_in_1;
    logic        ru_valid_out;
    logic [15:0] ru_out_0, ru_out_1;

    always #5 clk = ~clk;

    softmax_ru_sequencer #(
        .MAX_LEN (MAX_LEN),
        .ACC_W   (ACC_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_last      (in_last),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_last     (out_last),
        .busy         (busy),
        .len_err      (len_err),
        .ru_en        (ru_en),
        .ru_sel_mult  (ru_sel_mult),
        .ru_sel_mux   (ru_sel_mux),
        .ru_valid_in  (ru_valid_in),
        .ru_in_0      (ru_in_0),
        .ru_in_1      (ru_in_1),
        .ru_valid_out (ru_valid_out),
        .ru_out_0     (ru_out_0),
        .ru_out_1     (ru_out_1)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input int obs, input int exp, input int tol);
        n_checks++;
        if (obs - exp > tol || exp - obs > tol) begin
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) tol %0d",
                     tag, obs, obs, exp, exp, tol);
        end else begin
            n_pass++;
        end
    endtask

    function automatic int rnd(input real r);
        if (r >= 0.0) return $rtoi(r + 0.5);
        return -$rtoi(-r + 0.5);
    endfunction

    // ---------------- behavioural RU ----------------
    function automatic logic [31:0] ru_calc(input logic [15:0] a, input logic [15:0] b,
                                            input logic mux, input logic mult);
        real ra, rb, sub, d;
        int  tq, yq;
        ra = $itor($signed(a)) / 1024.0;
        rb = $itor($signed(b)) / 1024.0;
        if (mux) sub = ra;
        else if (ra <= 0.0) sub = -32.0;
        else sub = $itor(rnd($ln(ra) / $ln(2.0) * 1024.0)) / 1024.0;
        d = rb - sub;
        if (mult) d = d * 1476.0 / 1024.0;
        tq = rnd(d * 1024.0);
        if (tq > 32767) tq = 32767;
        if (tq < -32768) tq = -32768;
        yq = rnd($pow(2.0, $itor(tq) / 1024.0) * 1024.0);
        if (yq > 32767) yq = 32767;
        if (yq < 0) yq = 0;
        return {tq[15:0], yq[15:0]};
    endfunction

    logic [RU_DEPTH-1:0] ru_v;
    logic [15:0]         ru_t [RU_DEPTH];
    logic [15:0]         ru_y [RU_DEPTH];
    logic [31:0]         ru_res;

    assign ru_res = ru_calc(ru_in_0, ru_in_1, ru_sel_mux, ru_sel_mult);

    always @(posedge clk) begin
        if (rst) begin
            ru_v <= '0;
        end else if (ru_en) begin
            ru_v    <= {ru_v[RU_DEPTH-2:0], ru_valid_in};
            ru_t[0] <= ru_res[31:16];
            ru_y[0] <= ru_res[15:0];
            for (int i = 1; i < RU_DEPTH; i++) begin
                ru_t[i] <= ru_t[i-1];
                ru_y[i] <= ru_y[i-1];
            end
        end
    end

    assign ru_valid_out = ru_v[RU_DEPTH-1];
    assign ru_out_0     = ru_t[RU_DEPTH-1];
    assign ru_out_1     = ru_y[RU_DEPTH-1];

    // ---------------- reference model ----------------
    logic [15:0] cur [$];
    logic [16:0] exp_q [$];
    int          n_exp_pushed = 0;
    int          exp_len_err  = 0;

    task automatic finish_vec();
        logic signed [15:0] mx;
        real                ev [MAX_LEN];
        real                s;
        int                 n, p;
        n  = cur.size();
        mx = cur[0];
        for (int i = 1; i < n; i++) if ($signed(cur[i]) > mx) mx = cur[i];
        s = 0.0;
        for (int i = 0; i < n; i++) begin
            ev[i] = $exp(($itor($signed(cur[i])) - $itor(mx)) / 1024.0);
            s = s + ev[i];
        end
        // Sum fed to the RU is clamped to the largest positive Q6.10 value.
        if (s > 32767.0 / 1024.0) s = 32767.0 / 1024.0;
        for (int i = 0; i < n; i++) begin
            p = rnd(ev[i] / s * 1024.0);
            exp_q.push_back({(i == n - 1), 16'(p)});
            n_exp_pushed++;
        end
        cur.delete();
    endtask

    task automatic model_accept(input logic [15:0] x, input logic last);
        cur.push_back(x);
        if (last || cur.size() == MAX_LEN) begin
            if (!last) exp_len_err++;
            finish_vec();
        end
    endtask

    // ---------------- output side ----------------
    int          rdy_mode = 0;
    int          pat_i    = 0;
    int          n_out    = 0;
    int          len_err_seen = 0;
    logic        busy_chk = 1'b0;
    logic [16:0] mon_e;

    always @(negedge clk) begin
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            2: begin
                out_ready = (pat_i % 4 == 0) || (pat_i % 4 == 3);
                pat_i++;
            end
            default: out_ready = 1'b0;
        endcase
        #1;
        if (!rst) begin
            if (out_valid) check("ru_en_backpressure", int'(ru_en), int'(out_ready), 0);
            if (busy_chk) begin
                check("busy_after_last", int'(busy), 0, 0);
                busy_chk = 1'b0;
            end
            if (len_err) len_err_seen++;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", 1, 0, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("out_data", int'(out_data), int'(mon_e[15:0]), TOL);
                    check("out_last", int'(out_last), int'(mon_e[16]), 0);
                    if (out_last) busy_chk = 1'b1;
                    n_out++;
                end
            end
        end
    end

    // ---------------- input side ----------------
    task automatic send_beat(input logic [15:0] x, input logic last);
        int guard;
        in_valid = 1'b1;
        in_data  = x;
        in_last  = last;
        guard    = 0;
        while (!in_ready && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            check("in_ready_timeout", 0, 1, 0);
            in_valid = 1'b0;
            return;
        end
        model_accept(x, last);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int guard;
        guard = 0;
        while ((exp_q.size() != 0 || busy) && guard < 20000) begin
            @(negedge clk);
            guard++;
        end
        repeat (2) @(negedge clk);
        check({tag, "_drain_done"}, int'(guard < 20000), 1, 0);
        check({tag, "_out_count"}, n_out, n_exp_pushed, 0);
    endtask

    initial begin
        int guard;
        int n;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        in_last  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", int'(in_ready), 1, 0);
        check("rst_out_valid", int'(out_valid), 0, 0);
        check("rst_busy", int'(busy), 0, 0);
        check("rst_len_err", int'(len_err), 0, 0);
        check("rst_ru_valid_in", int'(ru_valid_in), 0, 0);
        check("rst_ru_en", int'(ru_en), 0, 0);
        check("rst_sel_mux", int'(ru_sel_mux), 0, 0);
        rst = 1'b0;
        @(negedge clk);

        // 1: four zeros
        for (int i = 0; i < 4; i++) send_beat(16'h0000, i == 3);
        wait_drain("t1");
        check("t1_len_err", len_err_seen, 0, 0);

        // 2: one hot at 1.0
        send_beat(16'h0400, 1'b0);
        for (int i = 1; i < 4; i++) send_beat(16'h0000, i == 3);
        wait_drain("t2");

        // 3: single negative beat
        send_beat(16'hF000, 1'b1);
        wait_drain("t3");

        // 4: overlong stream, cut at MAX_LEN; leftover forms a second vector
        for (int i = 0; i < MAX_LEN + 2; i++) send_beat(16'h0000, i == MAX_LEN + 1);
        wait_drain("t4");
        check("t4_len_err_count", len_err_seen, exp_len_err, 0);

        // 5: out_ready toggling 1-0-0-1
        rdy_mode = 2;
        for (int i = 0; i < 4; i++) send_beat(16'h0000, i == 3);
        wait_drain("t5");

        // 6: reset while results are stalled downstream
        rdy_mode = 3;
        send_beat(16'h0000, 1'b0);
        send_beat(16'h0000, 1'b1);
        guard = 0;
        while (!out_valid && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        check("t6_out_stalled", int'(out_valid), 1, 0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        n_exp_pushed = n_exp_pushed - exp_q.size();
        exp_q.delete();
        cur.delete();
        @(negedge clk);
        check("t6_rst_out_valid", int'(out_valid), 0, 0);
        check("t6_rst_in_ready", int'(in_ready), 1, 0);
        check("t6_rst_busy", int'(busy), 0, 0);
        rst = 1'b0;
        rdy_mode = 0;
        @(negedge clk);
        send_beat(16'h0000, 1'b0);
        send_beat(16'h0000, 1'b1);
        wait_drain("t6");

        // Random vectors with random backpressure
        rdy_mode = 1;
        for (int v = 0; v < 30; v++) begin
            n = $urandom_range(1, 8);
            for (int i = 0; i < n; i++) begin
                send_beat(16'($urandom_range(0, 16'h2000)) - 16'h1000, i == n - 1);
            end
        end
        wait_drain("rand");
        check("final_len_err_count", len_err_seen, exp_len_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
